// File: rtl/array_mult_pkg.sv
// rtl/array_mult_pkg.sv - shared types and constants for the sequential array multiplier
package array_mult_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Product width for a given operand width
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  localparam int DEF_PROD_W = prod_width(DEF_WIDTH);

endpackage

// File: rtl/array_row_adder.sv
// rtl/array_row_adder.sv - one array-multiplier level: psum + (bit AND operand)
module one_bit_half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module one_bit_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module array_row_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] psum_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH:0]   sum_o
);
  logic [WIDTH-1:0] pp;
  logic [WIDTH:1]   carry;

  assign pp = opnd_i & {WIDTH{bit_i}};

  // Ripple chain: half adder in the LSB, full adders above, carry-out is the MSB
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (i == 0) begin : g_ha
      one_bit_half_adder u_ha (
        .a_i(psum_i[0]), .b_i(pp[0]), .s_o(sum_o[0]), .c_o(carry[1])
      );
    end else begin : g_fa
      one_bit_full_adder u_fa (
        .a_i(psum_i[i]), .b_i(pp[i]), .c_i(carry[i]),
        .s_o(sum_o[i]), .c_o(carry[i+1])
      );
    end
  end

  assign sum_o[WIDTH] = carry[WIDTH];
endmodule

// File: rtl/array_seq_multiplier.sv
// rtl/array_seq_multiplier.sv - shift-add multiplier retiring one partial-product row per clock
module array_seq_multiplier
  import array_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            A,
  input  logic [WIDTH-1:0]            B,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [prod_width(WIDTH)-1:0] P,
  output logic                        busy
);
  localparam int PW = prod_width(WIDTH);

  state_e             state_q, state_d;
  logic [PW-1:0]      p_q, p_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH:0]     row;
  logic               last_row;

  assign last_row = (count_q == CNT_W'(WIDTH - 1));

  // Upper half of P accumulates; P[0] is the multiplier bit consumed this row
  array_row_adder #(.WIDTH(WIDTH)) u_row (
    .psum_i(p_q[PW-1:WIDTH]),
    .bit_i (p_q[0]),
    .opnd_i(b_q),
    .sum_o (row)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_row)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state; rst only masks in_ready
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Datapath next-state: capture in IDLE, shift-add in RUN, hold otherwise
  always_comb begin
    p_d     = p_q;
    b_d     = b_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (in_valid) begin
        p_d     = {{WIDTH{1'b0}}, A};
        b_d     = B;
        count_d = '0;
      end
      RUN: begin
        p_d     = {row, p_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q     <= '0;
      b_q     <= '0;
      count_q <= '0;
    end else begin
      p_q     <= p_d;
      b_q     <= b_d;
      count_q <= count_d;
    end
  end

  assign P = p_q;
endmodule

// File: tb/tb_array_seq_multiplier.sv
// tb/tb_array_seq_multiplier.sv - scoreboard bench for array_seq_multiplier
module tb_array_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] P;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int n_acc = 0;
  int n_ret = 0;
  logic [15:0] sb[$];

  array_seq_multiplier dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .P(P), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop and compare on retire, flush on reset
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        e = {8'h00, A};
        e = e * {8'h00, B};
        sb.push_back(e);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check_eq("sb_underflow", 1, 0);
        else                check_eq("sb_product", {16'h0, P}, {16'h0, sb.pop_front()});
        n_ret++;
      end
    end
  end

  // Accept one operand pair, check 8-edge latency and product, then retire it
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int n;
    A = a; B = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("ready_drop", in_ready, 0);
    check_eq("busy_run", busy, 1);
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check_eq("latency", n - 1, 8);
    check_eq("product", P, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("post_hs_valid", out_valid, 0);
    check_eq("post_hs_ready", in_ready, 1);
    check_eq("post_hs_busy", busy, 0);
    check_eq("post_hs_hold", P, exp);
  endtask

  initial begin
    int hi;
    int cyc;
    // Reset state
    rst = 1'b1;
    step(); step();
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_p", P, 0);
    rst = 1'b0;
    #1;
    check_eq("idle_ready", in_ready, 1);

    run_op(8'hFF, 8'hFF, 16'hFE01);
    run_op(8'h00, 8'hA5, 16'h0000);
    run_op(8'h80, 8'h02, 16'h0100);

    // Back-pressure with a competing operand
    A = 8'h0C; B = 8'h0D; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin step(); cyc++; end
    check_eq("bp_latency", cyc, 8);
    A = 8'h11; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_p", P, 16'h009C);
      check_eq("bp_ready", in_ready, 0);
      check_eq("bp_valid", out_valid, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("bp_idle_ready", in_ready, 1);
    step(); step();
    check_eq("bp_no_capture", busy, 0);
    check_eq("bp_hold_p", P, 16'h009C);

    // Reset in the middle of a run
    A = 8'h37; B = 8'h59; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_p", P, 0);
    check_eq("mid_rst_busy", busy, 0);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) hi++;
    end
    check_eq("mid_rst_no_valid", hi, 0);
    run_op(8'h03, 8'h05, 16'h000F);

    // Reset and in_valid together: reset wins
    rst = 1'b1; A = 8'h12; B = 8'h34; in_valid = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("sim_rst_busy", busy, 0);
    check_eq("sim_rst_ready", in_ready, 1);
    check_eq("sim_rst_p", P, 0);
    step();
    check_eq("sim_rst_still_idle", busy, 0);

    // Random traffic with consumer stalls
    n_acc = 0; n_ret = 0;
    cyc = 0;
    while (n_ret < 300 && cyc < 20000) begin
      in_valid  = (n_acc < 300) && ($urandom_range(0, 1) == 1);
      A         = 8'($urandom);
      B         = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("rand_accepted", n_acc, 300);
    check_eq("rand_retired", n_ret, 300);
    check_eq("rand_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
